// File: rtl/ysyx_040729_mem_responder.sv
// Memory-side responder serving the core's fetch and load/store ports from one 64-bit word array,
// with a fixed access latency, serialized arbitration, load extension and store byte masking.
module ysyx_040729_mem_responder #(
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            INST_WIDTH = 32,
  parameter int unsigned            MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 'h8000_0000,
  parameter int unsigned            LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_data_read,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [2:0]            mem_size,
  input  logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_write,
  output logic [DATA_WIDTH-1:0] mem_data_read,
  output logic                  mem_ready,
  input  logic                  fence_i,
  output logic                  bus_err
);

  localparam int unsigned           IdxW     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MemBytes = ADDR_WIDTH'(MEM_WORDS * 8);
  localparam logic [3:0]            CntInit  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic [1:0] {SrcMem, SrcIf, SrcFence} src_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  src_e                    src_q, acc_src;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              size_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    accept;
  logic                    commit;

  logic                    if_ready_q, mem_ready_q, bus_err_q;
  logic [INST_WIDTH-1:0]   if_data_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

  // Effective request: live inputs on the acceptance cycle, captured copy afterwards.
  src_e                    cur_src;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [2:0]              cur_size;
  logic                    cur_wen;
  logic [DATA_WIDTH-1:0]   cur_wdata;

  logic [ADDR_WIDTH-1:0]   off;
  logic                    oor;
  logic [IdxW-1:0]         idx;
  logic [2:0]              lane;
  logic [5:0]              shamt;
  logic [DATA_WIDTH-1:0]   word;
  logic [DATA_WIDTH-1:0]   ld_shift;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [INST_WIDTH-1:0]   fetch_word;
  logic                    misal;
  logic                    err;
  logic                    do_store;
  logic [7:0]              byte_base;
  logic [7:0]              byte_mask;
  logic [DATA_WIDTH-1:0]   bit_mask;
  logic [DATA_WIDTH-1:0]   wshift;
  logic [DATA_WIDTH-1:0]   new_word;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    acc_src = SrcMem;
    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          accept  = 1'b1;
          acc_src = SrcMem;
        end else if (if_valid) begin
          accept  = 1'b1;
          acc_src = SrcIf;
        end else if (fence_i) begin
          accept  = 1'b1;
          acc_src = SrcFence;
        end
        if (accept) begin
          if (acc_src == SrcFence || LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = CntInit;
          end
        end
      end
      StBusy: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign commit = (state_d == StResp);

  always_comb begin
    cur_src   = src_q;
    cur_addr  = addr_q;
    cur_size  = size_q;
    cur_wen   = wen_q;
    cur_wdata = wdata_q;
    if (state_q == StIdle) begin
      cur_src   = acc_src;
      cur_addr  = (acc_src == SrcIf) ? if_addr : mem_addr;
      cur_size  = mem_size;
      cur_wen   = mem_wen;
      cur_wdata = mem_data_write;
    end
  end

  assign off   = cur_addr - BASE_ADDR;
  assign oor   = (off >= MemBytes);
  assign idx   = off[IdxW+2:3];
  assign lane  = cur_addr[2:0];
  assign shamt = {lane, 3'b000};
  assign word  = mem_q[idx];

  always_comb begin
    misal     = 1'b0;
    byte_base = 8'h00;
    unique case (cur_size[1:0])
      2'd0: begin misal = 1'b0;        byte_base = 8'h01; end
      2'd1: begin misal = lane[0];     byte_base = 8'h03; end
      2'd2: begin misal = |lane[1:0];  byte_base = 8'h0F; end
      default: begin misal = |lane;    byte_base = 8'hFF; end
    endcase
  end

  always_comb begin
    err = 1'b0;
    if (cur_src == SrcMem) begin
      err = misal | oor | (cur_size == 3'b111) | (cur_wen & cur_size[2]);
    end else if (cur_src == SrcIf) begin
      err = (cur_addr[1:0] != 2'b00) | oor;
    end
  end

  assign ld_shift = word >> shamt;

  always_comb begin
    load_ext = '0;
    case (cur_size)
      3'b000:  load_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
      3'b001:  load_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  load_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
      3'b011:  load_ext = ld_shift;
      3'b100:  load_ext = {56'd0, ld_shift[7:0]};
      3'b101:  load_ext = {48'd0, ld_shift[15:0]};
      3'b110:  load_ext = {32'd0, ld_shift[31:0]};
      default: load_ext = '0;
    endcase
  end

  assign fetch_word = cur_addr[2] ? word[63:32] : word[31:0];

  // Store merge: only the addressed lanes take the shifted store data.
  assign byte_mask = byte_base << lane;
  assign wshift    = cur_wdata << shamt;

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
    end
  end

  assign new_word = (word & ~bit_mask) | (wshift & bit_mask);
  assign do_store = commit && (cur_src == SrcMem) && cur_wen && !err;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      src_q       <= SrcMem;
      addr_q      <= '0;
      size_q      <= 3'd0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        src_q   <= cur_src;
        addr_q  <= cur_addr;
        size_q  <= cur_size;
        wen_q   <= cur_wen;
        wdata_q <= cur_wdata;
      end
      if_ready_q  <= commit && (cur_src == SrcIf);
      mem_ready_q <= commit && (cur_src != SrcIf);
      if (commit && cur_src == SrcIf) begin
        if_data_q <= err ? '0 : fetch_word;
      end
      if (commit && cur_src == SrcMem && !cur_wen) begin
        mem_data_q <= err ? '0 : load_ext;
      end
      if (commit && err) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  // Array contents survive reset; an aborted access never reaches this write.
  always_ff @(posedge clock) begin
    if (!reset && do_store) begin
      mem_q[idx] <= new_word;
    end
  end

  assign if_ready      = if_ready_q;
  assign mem_ready     = mem_ready_q;
  assign if_data_read  = if_data_q;
  assign mem_data_read = mem_data_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_ysyx_040729_mem_responder.sv
// Directed bench for ysyx_040729_mem_responder: latency, arbitration, extension, masking,
// fence handling, error flagging and reset abort.
module tb_ysyx_040729_mem_responder;

  logic        clock;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data_read;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic        mem_wen;
  logic [63:0] mem_data_write;
  logic [63:0] mem_data_read;
  logic        mem_ready;
  logic        fence_i;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;

  ysyx_040729_mem_responder dut (
    .clock          (clock),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_addr        (if_addr),
    .if_ready       (if_ready),
    .if_data_read   (if_data_read),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_size       (mem_size),
    .mem_wen        (mem_wen),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read),
    .mem_ready      (mem_ready),
    .fence_i        (fence_i),
    .bus_err        (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with requests already driven; watches 12 cycles after the first edge.
  task automatic run(output int m_lat, output int i_lat, output int m_cnt, output int i_cnt);
    m_lat = 0; i_lat = 0; m_cnt = 0; i_cnt = 0;
    @(posedge clock);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (mem_ready) begin
        m_cnt++;
        if (m_lat == 0) m_lat = c;
        mem_valid = 1'b0;
        fence_i   = 1'b0;
      end
      if (if_ready) begin
        i_cnt++;
        if (i_lat == 0) i_lat = c;
        if_valid = 1'b0;
      end
    end
  endtask

  task automatic mem_op(input string tag, input logic [31:0] a, input logic [2:0] sz,
                        input logic w, input logic [63:0] d);
    int ml, il, mc, ic;
    mem_addr = a; mem_size = sz; mem_wen = w; mem_data_write = d; mem_valid = 1'b1;
    run(ml, il, mc, ic);
    check({tag, ".lat"}, 64'(ml), 64'd2);
    check({tag, ".cnt"}, 64'(mc), 64'd1);
  endtask

  task automatic fetch_op(input string tag, input logic [31:0] a);
    int ml, il, mc, ic;
    if_addr = a; if_valid = 1'b1;
    run(ml, il, mc, ic);
    check({tag, ".lat"}, 64'(il), 64'd2);
    check({tag, ".cnt"}, 64'(ic), 64'd1);
  endtask

  initial begin
    int ml, il, mc, ic;
    logic seen;
    reset = 1'b1; if_valid = 1'b0; if_addr = '0; mem_valid = 1'b0; mem_addr = '0;
    mem_size = 3'd0; mem_wen = 1'b0; mem_data_write = '0; fence_i = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst.if_ready", 64'(if_ready), 64'd0);
    check("rst.mem_ready", 64'(mem_ready), 64'd0);
    check("rst.bus_err", 64'(bus_err), 64'd0);
    reset = 1'b0;

    // Store/load round trip and fetch halves
    mem_op("sd8", 32'h8000_0008, 3'b011, 1'b1, 64'h1122_3344_5566_7788);
    mem_op("ld8", 32'h8000_0008, 3'b011, 1'b0, 64'd0);
    check("ld8.data", mem_data_read, 64'h1122_3344_5566_7788);
    fetch_op("if8", 32'h8000_0008);
    check("if8.data", 64'(if_data_read), 64'h5566_7788);
    fetch_op("ifc", 32'h8000_000C);
    check("ifc.data", 64'(if_data_read), 64'h1122_3344);
    mem_op("sd0", 32'h8000_0000, 3'b011, 1'b1, 64'd0);
    check("sd0.keep", mem_data_read, 64'h1122_3344_5566_7788);

    // Reset in BUSY aborts the store
    mem_addr = 32'h8000_0000; mem_size = 3'b011; mem_wen = 1'b1;
    mem_data_write = 64'hDEAD_BEEF_CAFE_F00D; mem_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mem_valid = 1'b0; reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("abort.mem_ready", 64'(mem_ready), 64'd0);
    check("abort.if_ready", 64'(if_ready), 64'd0);
    check("abort.if_data", 64'(if_data_read), 64'd0);
    check("abort.mem_data", mem_data_read, 64'd0);
    check("abort.bus_err", 64'(bus_err), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (mem_ready || if_ready) seen = 1'b1;
    end
    check("abort.noready", 64'(seen), 64'd0);
    mem_op("ld0", 32'h8000_0000, 3'b011, 1'b0, 64'd0);
    check("ld0.data", mem_data_read, 64'd0);

    // Byte store and extension
    mem_op("sb3", 32'h8000_0003, 3'b000, 1'b1, 64'hFFFF_FFFF_FFFF_FFAB);
    mem_op("lb3", 32'h8000_0003, 3'b000, 1'b0, 64'd0);
    check("lb3.data", mem_data_read, 64'hFFFF_FFFF_FFFF_FFAB);
    mem_op("lbu3", 32'h8000_0003, 3'b100, 1'b0, 64'd0);
    check("lbu3.data", mem_data_read, 64'h0000_0000_0000_00AB);
    mem_op("lw0", 32'h8000_0000, 3'b010, 1'b0, 64'd0);
    check("lw0.data", mem_data_read, 64'hFFFF_FFFF_AB00_0000);
    mem_op("lhu2", 32'h8000_0002, 3'b101, 1'b0, 64'd0);
    check("lhu2.data", mem_data_read, 64'h0000_0000_0000_AB00);
    mem_op("sh4", 32'h8000_0004, 3'b001, 1'b1, 64'h1234_5678_9ABC_CCDD);
    check("sh4.keep", mem_data_read, 64'h0000_0000_0000_AB00);
    mem_op("ld0b", 32'h8000_0000, 3'b011, 1'b0, 64'd0);
    check("ld0b.data", mem_data_read, 64'h0000_CCDD_AB00_0000);
    mem_op("lwu4", 32'h8000_0004, 3'b110, 1'b0, 64'd0);
    check("lwu4.data", mem_data_read, 64'h0000_0000_0000_CCDD);

    // Simultaneous mem and fetch: mem wins, fetch follows
    mem_addr = 32'h8000_0008; mem_size = 3'b011; mem_wen = 1'b0; mem_valid = 1'b1;
    if_addr = 32'h8000_0004; if_valid = 1'b1;
    run(ml, il, mc, ic);
    check("dual.mem_lat", 64'(ml), 64'd2);
    check("dual.if_lat", 64'(il), 64'd5);
    check("dual.mem_data", mem_data_read, 64'h1122_3344_5566_7788);
    check("dual.if_data", 64'(if_data_read), 64'h0000_CCDD);

    // Fences
    fence_i = 1'b1;
    run(ml, il, mc, ic);
    check("fence.lat", 64'(ml), 64'd1);
    check("fence.cnt", 64'(mc), 64'd1);
    check("fence.keep", mem_data_read, 64'h1122_3344_5566_7788);
    fence_i = 1'b1; if_addr = 32'h8000_0000; if_valid = 1'b1;
    run(ml, il, mc, ic);
    check("fif.if_lat", 64'(il), 64'd2);
    check("fif.mem_lat", 64'(ml), 64'd4);
    check("fif.if_data", 64'(if_data_read), 64'hAB00_0000);

    // Top of the array is in range
    mem_op("sdtop", 32'h8000_7FF8, 3'b011, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
    mem_op("ldtop", 32'h8000_7FF8, 3'b011, 1'b0, 64'd0);
    check("ldtop.data", mem_data_read, 64'hA5A5_5A5A_0F0F_F0F0);
    mem_op("sdtm1", 32'h8000_7FF0, 3'b011, 1'b1, 64'd0);
    check("top.bus_err", 64'(bus_err), 64'd0);

    // Errors
    mem_op("lwmis", 32'h8000_0002, 3'b010, 1'b0, 64'd0);
    check("lwmis.data", mem_data_read, 64'd0);
    check("lwmis.bus_err", 64'(bus_err), 64'd1);
    mem_op("swoor", 32'h7FFF_FFF0, 3'b010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("swoor.bus_err", 64'(bus_err), 64'd1);
    mem_op("ldalias", 32'h8000_7FF0, 3'b011, 1'b0, 64'd0);
    check("ldalias.data", mem_data_read, 64'd0);
    mem_op("sbu", 32'h8000_0000, 3'b100, 1'b1, 64'hFF);
    mem_op("ld0c", 32'h8000_0000, 3'b011, 1'b0, 64'd0);
    check("sbu.dropped", mem_data_read, 64'h0000_CCDD_AB00_0000);
    check("sticky.bus_err", 64'(bus_err), 64'd1);

    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("clr.bus_err", 64'(bus_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
